// File: rtl/trakball_pkg.sv
// trakball_emu shared types: axis FSM states, period type, trak_o
// and joystick bit layout.
package trakball_pkg;

    typedef enum logic [1:0] {
        AX_IDLE,
        AX_SETUP,
        AX_HIGH,
        AX_WAIT
    } axis_state_t;

    typedef logic [7:0] period_t;

    localparam int unsigned AXES = 4;

    // trak_o holds one {dir,clk} pair per axis, p1 H first
    localparam int unsigned TRAK_CLK = 0;
    localparam int unsigned TRAK_DIR = 1;

    localparam int unsigned JOY_UP    = 0;
    localparam int unsigned JOY_DOWN  = 1;
    localparam int unsigned JOY_LEFT  = 2;
    localparam int unsigned JOY_RIGHT = 3;

endpackage

// File: rtl/trakball_axis.sv
// One trackball axis engine: accelerating clk/dir pulse train.
// TRAKBALL_MOUSE_EN adds a saturating mouse delta accumulator.
module trakball_axis
    import trakball_pkg::*;
#(
    parameter period_t PER_START   = 8'd16,
    parameter period_t PER_MIN     = 8'd3,
    parameter int      ACCEL_EVERY = 4
) (
    input  logic              clk_i,
    input  logic              res_n_i,
    input  logic              tick,
    input  logic              req_pos,
    input  logic              req_neg,
`ifdef TRAKBALL_MOUSE_EN
    input  logic              mouse_stb,
    input  logic signed [7:0] mouse_d,
`endif
    output logic              clk_o,
    output logic              dir_o
);

    localparam period_t ACC_N = period_t'(ACCEL_EVERY);

    axis_state_t state_q, state_d;
    period_t     cnt_q, cnt_d;
    period_t     period_q, period_d;
    period_t     pcount_q, pcount_d;
    logic        clk_d, dir_d;
    logic        joy_act, req_act, req_dir;
    logic        enter;

    assign joy_act = req_pos ^ req_neg;

`ifdef TRAKBALL_MOUSE_EN
    logic signed [7:0] acc_q;
    logic signed [9:0] acc_sum;
    logic              mouse_src;

    assign mouse_src = !joy_act && (acc_q != 8'sd0);
    assign req_act   = joy_act || mouse_src;
    assign req_dir   = joy_act ? req_pos : !acc_q[7];

    always_comb begin
        acc_sum = 10'(acc_q);
        if (mouse_stb)
            acc_sum = acc_sum + 10'(mouse_d);
        // each mouse-driven pulse consumes one count
        if (enter && mouse_src)
            acc_sum = acc_q[7] ? acc_sum + 10'sd1
                               : acc_sum - 10'sd1;
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i)
            acc_q <= 8'sd0;
        else if (acc_sum > 10'sd127)
            acc_q <= 8'sd127;
        else if (acc_sum < -10'sd128)
            acc_q <= -8'sd128;
        else
            acc_q <= acc_sum[7:0];
    end
`else
    assign req_act = joy_act;
    assign req_dir = req_pos;
`endif

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            state_q  <= AX_IDLE;
            cnt_q    <= '0;
            period_q <= PER_START;
            pcount_q <= '0;
            clk_o    <= 1'b0;
            dir_o    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pcount_q <= pcount_d;
            clk_o    <= clk_d;
            dir_o    <= dir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        pcount_d = pcount_q;
        clk_d    = clk_o;
        dir_d    = dir_o;
        enter    = 1'b0;
        if (tick) begin
            unique case (state_q)
                AX_IDLE: begin
                    if (req_act) begin
                        enter    = 1'b1;
                        dir_d    = req_dir;
                        period_d = PER_START;
                        pcount_d = '0;
                    end
                end
                AX_SETUP: begin
                    state_d = AX_HIGH;
                    clk_d   = 1'b1;
                    cnt_d   = 8'd1;
                end
                AX_HIGH: begin
                    state_d = AX_WAIT;
                    clk_d   = 1'b0;
                    cnt_d   = 8'd2;
                end
                AX_WAIT: begin
                    if (cnt_q + 8'd1 < period_q) begin
                        cnt_d = cnt_q + 8'd1;
                    end else if (!req_act) begin
                        state_d  = AX_IDLE;
                        period_d = PER_START;
                        pcount_d = '0;
                    end else if (req_dir != dir_o) begin
                        enter    = 1'b1;
                        dir_d    = req_dir;
                        period_d = PER_START;
                        pcount_d = '0;
                    end else if (pcount_q + 8'd1 >= ACC_N) begin
                        enter    = 1'b1;
                        pcount_d = '0;
                        period_d = (period_q > PER_MIN)
                                 ? period_q - 8'd1 : PER_MIN;
                    end else begin
                        enter    = 1'b1;
                        pcount_d = pcount_q + 8'd1;
                    end
                end
                default: state_d = AX_IDLE;
            endcase
        end
        if (enter) begin
            state_d = AX_SETUP;
            cnt_d   = '0;
        end
`ifdef TRAKBALL_MOUSE_EN
        if (enter && mouse_src) begin
            period_d = PER_MIN;
            pcount_d = '0;
        end
`endif
    end

endmodule

// File: rtl/trakball_emu.sv
// Joystick-to-trackball quadrature emulator: tick prescaler + 4 axes.
// TRAKBALL_MOUSE_EN adds mouse delta inputs for player 1.
module trakball_emu
    import trakball_pkg::*;
#(
    parameter int CLK_HZ      = 12_000_000,
    parameter int TICK_HZ     = 4000,
    parameter int PER_START   = 16,
    parameter int PER_MIN     = 3,
    parameter int ACCEL_EVERY = 4
) (
    input  logic              clk_i,
    input  logic              res_n_i,
    input  logic [3:0]        joy1_i,
    input  logic [3:0]        joy2_i,
`ifdef TRAKBALL_MOUSE_EN
    input  logic              mouse_stb_i,
    input  logic signed [7:0] mouse_dx_i,
    input  logic signed [7:0] mouse_dy_i,
`endif
    output logic [7:0]        trak_o
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    // HIGH->WAIT already lands on cnt=2, so shorter periods cannot exist
    if (PER_MIN < 3) begin : g_per_min_chk
        $error("trakball_emu: PER_MIN must be >= 3");
    end

    logic [PW-1:0] pre_q;
    logic          tick;

    assign tick = (pre_q == PW'(DIV - 1));

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i)
            pre_q <= '0;
        else if (tick)
            pre_q <= '0;
        else
            pre_q <= pre_q + PW'(1);
    end

    for (genvar i = 0; i < AXES; i++) begin : g_axis
        localparam bit P2   = (i >= 2);
        localparam bit VERT = (i % 2) == 1;

        logic [3:0] joy;
        assign joy = P2 ? joy2_i : joy1_i;

        trakball_axis #(
            .PER_START  (period_t'(PER_START)),
            .PER_MIN    (period_t'(PER_MIN)),
            .ACCEL_EVERY(ACCEL_EVERY)
        ) u_axis (
            .clk_i    (clk_i),
            .res_n_i  (res_n_i),
            .tick     (tick),
            .req_pos  (VERT ? joy[JOY_DOWN] : joy[JOY_RIGHT]),
            .req_neg  (VERT ? joy[JOY_UP] : joy[JOY_LEFT]),
`ifdef TRAKBALL_MOUSE_EN
            .mouse_stb(P2 ? 1'b0 : mouse_stb_i),
            .mouse_d  (P2 ? 8'sd0
                          : (VERT ? mouse_dy_i : mouse_dx_i)),
`endif
            .clk_o    (trak_o[2*i + TRAK_CLK]),
            .dir_o    (trak_o[2*i + TRAK_DIR])
        );
    end

endmodule
